cpu_mem_arbiter: RTL and testbench



---
 rtl/cpu_mem_arbiter_pkg.sv | 26 ++
 rtl/cpu_mem_arbiter_if.sv | 34 +++
 rtl/cpu_mem_arbiter_rr_arbiter2.sv | 54 +++++
 rtl/cpu_mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types and constants for the CPU/host SRAM arbiter.
//   state_e      : arbiter FSM states (one-hot encodings)
//   req_id_e     : requester identifiers, also used as grant-vector indices
//   RESP_WR_DATA : response data returned for writes and dropped accesses
//   addr_in_range: true when a byte address falls inside the SRAM window
package cpu_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b001,
    S_ACCESS = 3'b010,
    S_RESP   = 3'b100
  } state_e;

  typedef enum logic {
    REQ_CPU  = 1'b0,
    REQ_HOST = 1'b1
  } req_id_e;

  localparam logic [31:0] RESP_WR_DATA = 32'h0;

  // SRAM spans 4 << aw bytes; anything with upper address bits set is outside.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned aw);
    return (addr >> (aw + 2)) == 32'd0;
  endfunction

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// Request/response channel between one requester (CPU or host bridge) and
// the SRAM arbiter.
//   req_valid/req_ready   : request handshake
//   req_wen               : 1 = write, 0 = read
//   req_addr              : byte address, bits [1:0] ignored
//   req_wdata/req_wstrb   : write data and byte strobes
//   resp_valid/resp_ready : response handshake
//   resp_rdata            : read data, 0 for writes
// master = requester side, slave = arbiter side.
interface cpu_mem_arbiter_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_wstrb;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/cpu_mem_arbiter_rr_arbiter2.sv
// Two-way request arbiter for the SRAM arbiter.
//   clk, resetn : clock, asynchronous active-low reset
//   req[1:0]    : request vector, index = req_id_e (0 CPU, 1 HOST)
//   en          : arbitration enabled (grant forced to 0 otherwise)
//   update      : a granted request was accepted this cycle
//   grant[1:0]  : one-hot grant
// Macro ARB_ROUND_ROBIN_EN: defined -> alternate on contention using the last
// grant (reset to HOST so the CPU wins first); undefined -> CPU fixed priority.
import cpu_mem_arbiter_pkg::*;

module rr_arbiter2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       update,
  output logic [1:0] grant
);

`ifdef ARB_ROUND_ROBIN_EN
  req_id_e r_last_grant;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_grant <= REQ_HOST;
    end else if (update) begin
      r_last_grant <= grant[REQ_HOST] ? REQ_HOST : REQ_CPU;
    end
  end

  always_comb begin
    grant = '0;
    if (en) begin
      if (req == 2'b11) begin
        grant = (r_last_grant == REQ_HOST) ? 2'b01 : 2'b10;
      end else begin
        grant = req;
      end
    end
  end
`else
  always_comb begin
    grant = '0;
    if (en) begin
      grant = req[REQ_CPU] ? 2'b01 : {req[REQ_HOST], 1'b0};
    end
  end

  // Fixed priority keeps no history.
  logic w_unused_rr;
  assign w_unused_rr = ^{clk, resetn, update};
`endif

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one single-port, 1-cycle-read-latency SRAM between the CPU memory
// port and the host-load port; one transaction in flight, one response per
// accepted request, returned to the requester that issued it.
//   clk, resetn          : clock, asynchronous active-low reset
//   cpu  (slave modport) : CPU request/response channel
//   host (slave modport) : host request/response channel
//   mem_en/mem_wen       : SRAM enable and byte write enables
//   mem_addr/mem_wdata   : SRAM word address and write data
//   mem_rdata            : SRAM read data, valid one cycle after mem_en
// Macro ARB_ROUND_ROBIN_EN selects round-robin arbitration (see rr_arbiter2).
import cpu_mem_arbiter_pkg::*;

module cpu_mem_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MEM_AW = 12
) (
  input  logic              clk,
  input  logic              resetn,
  cpu_mem_arbiter_if.slave  cpu,
  cpu_mem_arbiter_if.slave  host,
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            r_state;
  state_e            w_state_nxt;
  req_id_e           r_owner;
  logic              r_wen;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_resp_valid;
  logic              r_first;
  logic              r_live;
  logic [DATA_W-1:0] r_rdata;

  logic [1:0]        w_grant;
  logic              w_arb_en;
  logic              w_hs;
  logic              w_in_range;
  logic              w_resp_hs;
  logic [DATA_W-1:0] w_resp_data;

  assign w_arb_en   = (r_state == S_IDLE);
  assign w_hs       = |w_grant;
  assign w_in_range = addr_in_range(r_addr, MEM_AW);
  assign w_resp_hs  = r_resp_valid &
                      ((r_owner == REQ_CPU) ? cpu.resp_ready : host.resp_ready);

  rr_arbiter2 u_arb (
    .clk    (clk),
    .resetn (resetn),
    .req    ({host.req_valid, cpu.req_valid}),
    .en     (w_arb_en),
    .update (w_hs),
    .grant  (w_grant)
  );

  // SRAM data only arrives in the first response cycle, so that cycle passes
  // it straight through; it is captured there and replayed from r_rdata for
  // the rest of the response, keeping the data stable under backpressure.
  assign w_resp_data = r_first ? (r_live ? mem_rdata : DATA_W'(RESP_WR_DATA)) : r_rdata;

  assign cpu.resp_valid  = r_resp_valid & (r_owner == REQ_CPU);
  assign host.resp_valid = r_resp_valid & (r_owner == REQ_HOST);
  assign cpu.resp_rdata  = (r_owner == REQ_CPU)  ? w_resp_data : '0;
  assign host.resp_rdata = (r_owner == REQ_HOST) ? w_resp_data : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    cpu.req_ready  = 1'b0;
    host.req_ready = 1'b0;
    mem_en         = 1'b0;
    mem_wen        = '0;
    mem_addr       = '0;
    mem_wdata      = '0;
    case (r_state)
      S_IDLE: begin
        // Gated by resetn so ready is 0 for the whole reset pulse.
        cpu.req_ready  = w_grant[REQ_CPU] & resetn;
        host.req_ready = w_grant[REQ_HOST] & resetn;
        if (w_hs) begin
          w_state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (w_in_range) begin
          mem_en    = 1'b1;
          mem_wen   = r_wen ? r_wstrb : 4'h0;
          mem_addr  = r_addr[MEM_AW+1:2];
          mem_wdata = r_wen ? r_wdata : '0;
        end
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (w_resp_hs) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_owner      <= REQ_CPU;
      r_wen        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_resp_valid <= 1'b0;
      r_first      <= 1'b0;
      r_live       <= 1'b0;
      r_rdata      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            if (w_grant[REQ_HOST]) begin
              r_owner <= REQ_HOST;
              r_wen   <= host.req_wen;
              r_addr  <= host.req_addr;
              r_wdata <= host.req_wdata;
              r_wstrb <= host.req_wstrb;
            end else begin
              r_owner <= REQ_CPU;
              r_wen   <= cpu.req_wen;
              r_addr  <= cpu.req_addr;
              r_wdata <= cpu.req_wdata;
              r_wstrb <= cpu.req_wstrb;
            end
          end
        end
        S_ACCESS: begin
          r_resp_valid <= 1'b1;
          r_first      <= 1'b1;
          r_live       <= ~r_wen & w_in_range;
        end
        S_RESP: begin
          r_first <= 1'b0;
          if (w_resp_hs) begin
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
          end else if (r_first) begin
            r_rdata <= w_resp_data;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
module tb_cpu_mem_arbiter;

  localparam int MEM_WORDS = 4096;
  localparam logic [31:0] MEM_BYTES = 32'h4000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cpu_mem_arbiter_if #(.DATA_W(32)) cpu_if ();
  cpu_mem_arbiter_if #(.DATA_W(32)) host_if ();

  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  cpu_mem_arbiter #(.DATA_W(32), .MEM_AW(12)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cpu       (cpu_if.slave),
    .host      (host_if.slave),
    .mem_en    (mem_en),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // SRAM macro model: 1-cycle read latency, output held when not enabled.
  logic [31:0] sram [0:MEM_WORDS-1];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_wen[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= sram[mem_addr];
    end
  end

  // Reference: memory contents as seen by completed transactions.
  logic [31:0] ref_mem [0:MEM_WORDS-1];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic drive(input bit h, input bit v, input bit wen, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] strb);
    if (h) begin
      host_if.req_valid = v; host_if.req_wen = wen; host_if.req_addr = addr;
      host_if.req_wdata = wd; host_if.req_wstrb = strb;
    end else begin
      cpu_if.req_valid = v; cpu_if.req_wen = wen; cpu_if.req_addr = addr;
      cpu_if.req_wdata = wd; cpu_if.req_wstrb = strb;
    end
  endtask

  function automatic logic rdy(input bit h);
    return h ? host_if.req_ready : cpu_if.req_ready;
  endfunction
  function automatic logic rvld(input bit h);
    return h ? host_if.resp_valid : cpu_if.resp_valid;
  endfunction
  function automatic logic [31:0] rdat(input bit h);
    return h ? host_if.resp_rdata : cpu_if.resp_rdata;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] addr);
    logic [11:0] idx;
    idx = addr[13:2];
    return (addr < MEM_BYTES) ? ref_mem[idx] : 32'h0;
  endfunction

  // One complete transaction from an idle arbiter, resp_ready high.
  // Entered and left just after a rising edge.
  task automatic do_txn(input string tag, input bit h, input bit wen, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] strb);
    logic [31:0] exp_rd;
    logic [11:0] idx;
    bit inr;
    int n;
    inr = addr < MEM_BYTES;
    idx = addr[13:2];
    exp_rd = wen ? 32'h0 : exp_read(addr);
    drive(h, 1'b1, wen, addr, wd, strb);
    n = 0;
    do begin @(negedge clk); n++; end while (!rdy(h) && n < 20);
    chk({tag, ":req_ready"}, 32'(rdy(h)), 32'd1);
    chk({tag, ":other_ready"}, 32'(rdy(!h)), 32'd0);
    @(posedge clk); #1;
    drive(h, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk({tag, ":mem_en"}, 32'(mem_en), 32'(inr));
    chk({tag, ":mem_wen"}, 32'(mem_wen), (wen && inr) ? 32'(strb) : 32'h0);
    if (inr) chk({tag, ":mem_addr"}, 32'(mem_addr), 32'(idx));
    if (inr && wen) chk({tag, ":mem_wdata"}, mem_wdata, wd);
    @(negedge clk);
    chk({tag, ":resp_valid"}, 32'(rvld(h)), 32'd1);
    chk({tag, ":resp_rdata"}, rdat(h), exp_rd);
    chk({tag, ":other_resp_valid"}, 32'(rvld(!h)), 32'd0);
    if (wen && inr) ref_mem[idx] = merge(ref_mem[idx], wd, strb);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_host, tb_last;
    int n;
    logic [31:0] a, exp_rd;

    for (int i = 0; i < MEM_WORDS; i++) begin sram[i] = 32'h0; ref_mem[i] = 32'h0; end
    sram[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    cpu_if.resp_ready = 1'b1;
    host_if.resp_ready = 1'b1;

    // Reset state
    #2;
    chk("rst:cpu_resp_valid", 32'(cpu_if.resp_valid), 32'd0);
    chk("rst:host_resp_valid", 32'(host_if.resp_valid), 32'd0);
    chk("rst:mem_en", 32'(mem_en), 32'd0);
    chk("rst:mem_addr", 32'(mem_addr), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_txn("cpu_rd_deadbeef", 1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
    do_txn("host_wr_0c", 1'b1, 1'b1, 32'h0C, 32'h12345678, 4'b0101);
    do_txn("host_rd_0c", 1'b1, 1'b0, 32'h0C, 32'h0, 4'h0);
    chk("host_wr_merge_model", ref_mem[3], 32'h00340078);
    do_txn("cpu_rd_oor", 1'b0, 1'b0, 32'h0001_0000, 32'h0, 4'h0);
    do_txn("cpu_rd_after_oor", 1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
    do_txn("host_wr_oor", 1'b1, 1'b1, 32'h0001_0010, 32'hFFFFFFFF, 4'hF);
    do_txn("host_wr_nostrb", 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
    do_txn("cpu_rd_nostrb", 1'b0, 1'b0, 32'h20, 32'h0, 4'h0);

    // Response backpressure on the CPU port with a host request waiting
    exp_rd = exp_read(32'h10);
    cpu_if.resp_ready = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    n = 0;
    do begin @(negedge clk); n++; end while (!cpu_if.req_ready && n < 20);
    chk("bp:cpu_req_ready", 32'(cpu_if.req_ready), 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0C, 32'h0, 4'h0);
    @(negedge clk);
    chk("bp:host_ready_access", 32'(host_if.req_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp:cpu_resp_valid", 32'(cpu_if.resp_valid), 32'd1);
      chk("bp:cpu_rdata_stable", cpu_if.resp_rdata, exp_rd);
      chk("bp:host_ready_stall", 32'(host_if.req_ready), 32'd0);
    end
    cpu_if.resp_ready = 1'b1;
    @(negedge clk);
    chk("bp:host_accepted_next", 32'(host_if.req_ready), 32'd1);
    chk("bp:cpu_resp_done", 32'(cpu_if.resp_valid), 32'd0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk); @(negedge clk);
    chk("bp:host_resp_valid", 32'(host_if.resp_valid), 32'd1);
    chk("bp:host_rdata", host_if.resp_rdata, exp_read(32'h0C));
    @(posedge clk); #1;

    // Reset in the middle of an access
    drive(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    n = 0;
    do begin @(negedge clk); n++; end while (!cpu_if.req_ready && n < 20);
    chk("rstmid:req_ready", 32'(cpu_if.req_ready), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid:mem_en_before", 32'(mem_en), 32'd1);
    #1 resetn = 1'b0;
    #1;
    chk("rstmid:cpu_req_ready", 32'(cpu_if.req_ready), 32'd0);
    chk("rstmid:host_req_ready", 32'(host_if.req_ready), 32'd0);
    chk("rstmid:cpu_resp_valid", 32'(cpu_if.resp_valid), 32'd0);
    chk("rstmid:host_resp_valid", 32'(host_if.resp_valid), 32'd0);
    chk("rstmid:cpu_rdata", cpu_if.resp_rdata, 32'h0);
    chk("rstmid:host_rdata", host_if.resp_rdata, 32'h0);
    chk("rstmid:mem_en", 32'(mem_en), 32'd0);
    chk("rstmid:mem_wen", 32'(mem_wen), 32'd0);
    chk("rstmid:mem_addr", 32'(mem_addr), 32'd0);
    chk("rstmid:mem_wdata", mem_wdata, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstmid:no_resp", 32'(cpu_if.resp_valid), 32'd0);
    end
    @(posedge clk); #1;

    // Both requesters valid every cycle, fresh from reset
    tb_last = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0C, 32'h0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(negedge clk); n++; end
        while (!(cpu_if.req_ready || host_if.req_ready) && n < 20);
`ifdef ARB_ROUND_ROBIN_EN
      exp_host = !tb_last;
`else
      exp_host = 1'b0;
`endif
      chk("both:host_grant", 32'(host_if.req_ready), 32'(exp_host));
      chk("both:cpu_grant", 32'(cpu_if.req_ready), 32'(!exp_host));
      chk("both:back_to_back", 32'(n), 32'd1);
      tb_last = exp_host;
      @(posedge clk); #1;
      if (k == 3) begin
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
`ifdef ARB_ROUND_ROBIN_EN
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
`endif
      end
      @(negedge clk); @(negedge clk);
      chk("both:resp_valid", 32'(rvld(exp_host)), 32'd1);
      chk("both:resp_rdata", rdat(exp_host), exp_read(exp_host ? 32'h0C : 32'h10));
      @(posedge clk); #1;
    end
`ifndef ARB_ROUND_ROBIN_EN
    n = 0;
    do begin @(negedge clk); n++; end while (!host_if.req_ready && n < 20);
    chk("both:host_finally", 32'(host_if.req_ready), 32'd1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk); @(negedge clk);
    chk("both:host_resp", host_if.resp_rdata, exp_read(32'h0C));
    @(posedge clk); #1;
`endif

    // Randomized single-requester traffic against the reference memory
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom | MEM_BYTES;
      else a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      do_txn("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
             $urandom, 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
